seq_alu_unit: RTL and testbench
===============================

// Module: seq_alu_unit
// PURPOSE
//   Parametrised, registered successor to the 8-bit sum/minus cells.
//   Executes ADD/SUB/AND/OR/XOR/SHL/SHR in one cycle and unsigned MUL iteratively (shift-add).
//   Produces Z/N/C/V flags and uses valid/ready handshakes on both sides.
//   Sits between the decode stage and the register-file writeback of the JSilicon core.
// PARAMETERS
//   WIDTH   8            operand/result width; must be >= 2
//   SHW     $clog2(WIDTH) shift-amount width; taken from b[SHW-1:0]
// PORTS
//   clk        in   1       single clock; all state updates on its rising edge
//   rst_n      in   1       reset; synchronous, active-low
//   in_valid   in   1       operands/op are presented
//   in_ready   out  1       unit can accept; high only in IDLE
//   op         in   3       opcode (see package)
//   a          in   WIDTH   operand A
//   b          in   WIDTH   operand B / shift amount
//   out_valid  out  1       result and flags valid
//   out_ready  in   1       consumer accepts result
//   res_lo     out  WIDTH   result; product low half for MUL
//   res_hi     out  WIDTH   product high half for MUL; 0 for all other ops
//   flags      out  4       {Z,N,C,V}
// BEHAVIOUR
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL. All 8 codes are defined.
//   Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, res_lo=res_hi=0, flags=0, counter=0.
//     Reset aborts any in-flight MUL; there is no partial output.
//   FSM states: IDLE, MUL, DONE.
//     IDLE: in_ready=1. On in_valid, latch a, b, op.
//       Non-MUL op -> result registered at the same edge -> DONE; latency 1 cycle.
//       MUL -> clear acc and cnt -> MUL.
//     MUL: each cycle, if mplier[0]==1 add mcand<<cnt into the 2*WIDTH accumulator; shift mplier right; cnt++.
//       After WIDTH iterations -> DONE.
//       out_valid rises exactly WIDTH+1 cycles after the accepting edge.
//     DONE: out_valid=1. res_lo, res_hi and flags are held stable while out_ready=0.
//       On out_ready -> IDLE; out_valid falls on the next cycle.
//     in_ready=0 in MUL and DONE; in_valid is ignored there (no accept-while-busy).
//   Width rules: ADD/SUB wrap modulo 2^WIDTH. MUL is unsigned WIDTH x WIDTH -> 2*WIDTH.
//   Flags (Z and N always computed from res_lo):
//     Z = (res_lo==0); N = res_lo[WIDTH-1].
//     ADD: C = carry-out; V = signed overflow.
//     SUB: C = borrow (a<b unsigned); V = signed overflow.
//     AND/OR/XOR: C=0, V=0.
//     SHL/SHR: C = last bit shifted out; shift amount 0 -> result=a, C=0; V=0.
//     MUL: C = V = (res_hi != 0).
//   No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//   Package alu_pkg:
//     - op localparams OP_ADD..OP_MUL (3 bits)
//     - state encoding ST_IDLE/ST_MUL/ST_DONE
//     - flag bit indices F_Z=3, F_N=2, F_C=1, F_V=0
//   Sub-module addsub_cell #(WIDTH): inputs a, b, sub; outputs y, cout, ovf.
//     Kept with (* keep_hierarchy *).
//     One instance serves ADD/SUB; the MUL accumulate uses a separate 2*WIDTH adder inline.
//   Top-level holds the FSM, operand registers, MUL counter/accumulator and output registers.
// TESTING (WIDTH=8 unless noted)
//   1. ADD 0xFF+0x01 -> res_lo=0x00, flags Z=1 N=0 C=1 V=0; out_valid 1 cycle after accept.
//   2. SUB 0x80-0x01 -> 0x7F, Z=0 N=0 C=0 V=1; SUB 0x00-0x01 -> 0xFF, N=1 C=1 V=0.
//   3. MUL 0xFF*0xFF -> res_hi=0xFE, res_lo=0x01, C=V=1, out_valid at cycle 9.
//      MUL 0x0F*0x11 -> hi=0x00, lo=0xFF, C=0.
//   4. SHL 0x81 by 1 -> 0x02, C=1; SHR 0x01 by 1 -> 0x00, Z=1, C=1; SHL by 0 -> a, C=0.
//   5. Hold out_ready=0 for 5 cycles in DONE:
//      -> outputs stable, in_ready=0, a second in_valid is ignored.
//      Release -> IDLE, then accept the next op.
//   6. Assert rst_n=0 during cycle 4 of a MUL:
//      -> next cycle IDLE, out_valid=0, outputs 0; then ADD 2+3 -> 0x05.
//   Also run case 1 and case 3 with WIDTH=16: 0xFFFF+1 -> 0, C=1; 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/addsub_cell.sv
// Shared adder/subtractor; cout reports borrow when subtracting.
module addsub_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  assign b_eff = b ^ {WIDTH{sub}};
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign y     = sum[WIDTH-1:0];
  // Carry of a + ~b + 1 is the inverse of the borrow.
  assign cout  = sum[WIDTH] ^ sub;
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu_unit.sv
// Registered ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL,
// valid/ready handshakes on both sides.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH-1:0]   as_y;
  logic               as_cout;
  logic               as_ovf;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;

  (* keep_hierarchy *)
  addsub_cell #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (op == OP_SUB),
    .y    (as_y),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // The extra bit of each shift holds the last bit shifted out (0 for amount 0).
  assign shamt   = b[SHW-1:0];
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = as_y;
        alu_c   = as_cout;
        alu_v   = as_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  assign addend  = {{WIDTH{1'b0}}, mcand_reg} << cnt_reg;
  assign acc_sum = acc_reg + (mplier_reg[0] ? addend : '0);

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      res_lo     <= '0;
      res_hi     <= '0;
      flags      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand_reg  <= a;
              mplier_reg <= b;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              state_reg  <= ST_MUL;
            end else begin
              res_lo           <= alu_res;
              res_hi           <= '0;
              flags[F_Z]       <= (alu_res == '0);
              flags[F_N]       <= alu_res[WIDTH-1];
              flags[F_C]       <= alu_c;
              flags[F_V]       <= alu_v;
              state_reg        <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          // One extra cycle after the last iteration moves the product to the outputs.
          if (cnt_reg == CW'(WIDTH)) begin
            res_lo     <= acc_reg[WIDTH-1:0];
            res_hi     <= acc_reg[2*WIDTH-1:WIDTH];
            flags[F_Z] <= (acc_reg[WIDTH-1:0] == '0);
            flags[F_N] <= acc_reg[WIDTH-1];
            flags[F_C] <= (acc_reg[2*WIDTH-1:WIDTH] != '0);
            flags[F_V] <= (acc_reg[2*WIDTH-1:WIDTH] != '0);
            state_reg  <= ST_DONE;
          end else begin
            acc_reg    <= acc_sum;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Scoreboard bench for seq_alu_unit at WIDTH=8 (full set) and WIDTH=16 (ADD/MUL corners).
module tb_seq_alu_unit;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0, res_lo8, res_hi8;
  logic [3:0] flags8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res_lo16, res_hi16;
  logic [3:0]  flags16;

  seq_alu_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .res_lo(res_lo8), .res_hi(res_hi8), .flags(flags8)
  );

  seq_alu_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .res_lo(res_lo16), .res_hi(res_hi16), .flags(flags16)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q8[$];
  exp_t exp_q16[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model for WIDTH=8, written from the opcode definitions in integer arithmetic.
  function automatic exp_t model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ai, bi, sa, sb, r, sh, p;
    logic c, v;
    ai = int'(a); bi = int'(b);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    sh = bi % 8;
    c = 1'b0; v = 1'b0; r = 0;
    e.hi = 16'h0;
    e.lat = 0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd1: begin r = ai - bi; c = (ai < bi); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin r = ai << sh; c = (sh == 0) ? 1'b0 : 1'((ai >> (8 - sh)) & 1); end
      3'd6: begin r = ai >> sh; c = (sh == 0) ? 1'b0 : 1'((ai >> (sh - 1)) & 1); end
      default: begin
        p = ai * bi;
        r = p;
        e.hi = 16'((p >> 8) & 255);
        c = (e.hi != 0); v = c;
        e.lat = 9;
      end
    endcase
    e.lo = 16'(r & 255);
    e.fl = {e.lo == 16'h0, e.lo[7], c, v};
    return e;
  endfunction

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_wait8", 32'(in_ready8), 32'd1);
    in_valid8 = 1'b1; op8 = op; a8 = a; b8 = b;
    exp_q8.push_back(model8(op, a, b));
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic recv8(input int hold, input bit ghost);
    int n = 0;
    exp_t e;
    logic [7:0] lo_s;
    logic [3:0] fl_s;
    while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    check("out_valid8", 32'(out_valid8), 32'd1);
    e = exp_q8.pop_front();
    check("latency8", n, e.lat);
    check("res_lo8", 32'(res_lo8), 32'(e.lo));
    check("res_hi8", 32'(res_hi8), 32'(e.hi));
    check("flags8", 32'(flags8), 32'(e.fl));
    check("busy_ready8", 32'(in_ready8), 32'd0);
    $display("txn w8 op=%0d a=%02h b=%02h lo=%02h hi=%02h flags=%04b lat=%0d",
             op8, a8, b8, res_lo8, res_hi8, flags8, n);
    lo_s = res_lo8; fl_s = flags8;
    for (int i = 0; i < hold; i++) begin
      if (ghost) begin in_valid8 = 1'b1; op8 = 3'd4; a8 = 8'hA5; b8 = 8'h3C; end
      @(posedge clk); #1;
      check("hold_lo8", 32'(res_lo8), 32'(lo_s));
      check("hold_flags8", 32'(flags8), 32'(fl_s));
      check("hold_valid8", 32'(out_valid8), 32'd1);
      check("hold_ready8", 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("drop_valid8", 32'(out_valid8), 32'd0);
    check("idle_ready8", 32'(in_ready8), 32'd1);
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    exp_t e;
    while (!in_ready16 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_wait16", 32'(in_ready16), 32'd1);
    in_valid16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 40) begin @(posedge clk); #1; n++; end
    check("out_valid16", 32'(out_valid16), 32'd1);
    e = exp_q16.pop_front();
    check("latency16", n, e.lat);
    check("res_lo16", 32'(res_lo16), 32'(e.lo));
    check("res_hi16", 32'(res_hi16), 32'(e.hi));
    check("flags16", 32'(flags16), 32'(e.fl));
    $display("txn w16 op=%0d a=%04h b=%04h lo=%04h hi=%04h flags=%04b lat=%0d",
             op, a, b, res_lo16, res_hi16, flags16, n);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("drop_valid16", 32'(out_valid16), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid8), 32'd0);
    check("rst_ready", 32'(in_ready8), 32'd1);
    check("rst_lo", 32'(res_lo8), 32'd0);
    check("rst_hi", 32'(res_hi8), 32'd0);
    check("rst_flags", 32'(flags8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send8(3'd0, 8'hFF, 8'h01); recv8(0, 1'b0);
    send8(3'd1, 8'h80, 8'h01); recv8(0, 1'b0);
    send8(3'd1, 8'h00, 8'h01); recv8(0, 1'b0);
    send8(3'd7, 8'hFF, 8'hFF); recv8(0, 1'b0);
    send8(3'd7, 8'h0F, 8'h11); recv8(0, 1'b0);
    send8(3'd5, 8'h81, 8'h01); recv8(0, 1'b0);
    send8(3'd6, 8'h01, 8'h01); recv8(0, 1'b0);
    send8(3'd5, 8'h5A, 8'h00); recv8(0, 1'b0);
    send8(3'd6, 8'h80, 8'h07); recv8(0, 1'b0);
    send8(3'd2, 8'hF0, 8'h3C); recv8(0, 1'b0);
    send8(3'd3, 8'h00, 8'h00); recv8(0, 1'b0);
    send8(3'd4, 8'hAA, 8'h55); recv8(0, 1'b0);

    // Back-pressure with a stray request during DONE, then a normal op.
    send8(3'd0, 8'h10, 8'h20); recv8(5, 1'b1);
    send8(3'd1, 8'h05, 8'h07); recv8(0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      recv8(i % 3, 1'b0);
    end

    // Reset during the fourth cycle of a multiply.
    send8(3'd7, 8'hC3, 8'h5D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    void'(exp_q8.pop_front());
    check("abort_valid", 32'(out_valid8), 32'd0);
    check("abort_ready", 32'(in_ready8), 32'd1);
    check("abort_lo", 32'(res_lo8), 32'd0);
    check("abort_hi", 32'(res_hi8), 32'd0);
    check("abort_flags", 32'(flags8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(3'd0, 8'h02, 8'h03); recv8(0, 1'b0);

    exp_q16.push_back('{lo: 16'h0000, hi: 16'h0000, fl: 4'b1010, lat: 0});
    run16(3'd0, 16'hFFFF, 16'h0001);
    exp_q16.push_back('{lo: 16'h0001, hi: 16'hFFFE, fl: 4'b0011, lat: 17});
    run16(3'd7, 16'hFFFF, 16'hFFFF);

    check("sb_empty8", 32'(exp_q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
